// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : pipe_pkg
//  Description : Shared pipeline encodings for the W stage: result-select
//                codes, load-type codes and the hard-wired zero register.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Result select codes (6 and 7 fall back to the ALU result)
    localparam logic [2:0] WB_SEL_ALU = 3'd0;
    localparam logic [2:0] WB_SEL_MEM = 3'd1;
    localparam logic [2:0] WB_SEL_PC8 = 3'd2;
    localparam logic [2:0] WB_SEL_HI  = 3'd3;
    localparam logic [2:0] WB_SEL_LO  = 3'd4;
    localparam logic [2:0] WB_SEL_IMM = 3'd5;

    // Load type codes (5..7 behave as a full word load)
    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    // Register 0 always reads as zero and ignores writes
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/wb_stage_grf_load_ext.sv
`default_nettype none
// ============================================================================
//  Module      : load_ext
//  Description : Sub-word load extraction. Picks the addressed byte or half
//                from the raw memory word and sign- or zero-extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_ext
    import pipe_pkg::*;
(
    input  logic [31:0] dm_out,
    input  logic [1:0]  off,
    input  logic [2:0]  ld_type,
    output logic [31:0] ext_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select: byte by full offset, half by offset bit 1 only
    always_comb begin
        byte_sel = dm_out[7:0];
        case (off)
            2'd0:    byte_sel = dm_out[7:0];
            2'd1:    byte_sel = dm_out[15:8];
            2'd2:    byte_sel = dm_out[23:16];
            default: byte_sel = dm_out[31:24];
        endcase
        half_sel = off[1] ? dm_out[31:16] : dm_out[15:0];
    end

    // Extension by load type; unknown codes pass the word through
    always_comb begin
        ext_out = dm_out;
        case (ld_type)
            LD_B:    ext_out = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   ext_out = {24'h0, byte_sel};
            LD_H:    ext_out = {{16{half_sel[15]}}, half_sel};
            LD_HU:   ext_out = {16'h0, half_sel};
            default: ext_out = dm_out;
        endcase
    end

endmodule : load_ext
`default_nettype wire

// File: rtl/wb_stage_grf.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_grf
//  Description : Write-back stage with 32x32 general register file. Selects
//                the W-stage result, writes the GRF, serves two D-stage read
//                ports with same-cycle W->D bypass, counts retired writes.
//  Config      : WB_TRACE_EN - when defined, prints one trace line per
//                effective register write (simulation only).
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_grf
    import pipe_pkg::*;
#(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_en,
    input  logic [2:0]    wb_sel,
    input  logic [2:0]    ld_type,
    input  logic [4:0]    a3,
    input  logic [DW-1:0] alu_out,
    input  logic [DW-1:0] dm_out,
    input  logic [DW-1:0] imm,
    input  logic [DW-1:0] hi,
    input  logic [DW-1:0] lo,
    input  logic [DW-1:0] pc8,
    input  logic [DW-1:0] pc4,
    input  logic [4:0]    ra1,
    input  logic [4:0]    ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic [DW-1:0] wd_w,
    output logic          we_w,
    output logic [31:0]   retire_cnt
);

    logic [DW-1:0] grf_q [NREG];
    logic [31:0]   cnt_q;
    logic [31:0]   cnt_d;
    logic [DW-1:0] mem_ext;

    load_ext u_load_ext (
        .dm_out  (dm_out),
        .off     (alu_out[1:0]),
        .ld_type (ld_type),
        .ext_out (mem_ext)
    );

    // W-stage result mux; undefined select codes fall back to the ALU result
    always_comb begin
        wd_w = alu_out;
        case (wb_sel)
            WB_SEL_MEM: wd_w = mem_ext;
            WB_SEL_PC8: wd_w = pc8;
            WB_SEL_HI:  wd_w = hi;
            WB_SEL_LO:  wd_w = lo;
            WB_SEL_IMM: wd_w = imm;
            default:    wd_w = alu_out;
        endcase
    end

    assign we_w       = wb_en && (a3 != REG_ZERO) && !reset;
    assign cnt_d      = cnt_q + 32'd1;
    assign retire_cnt = cnt_q;

    // Read ports: zero register, then same-cycle bypass, then array contents
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (!reset) begin
            if (ra1 != REG_ZERO)
                rd1 = (we_w && (a3 == ra1)) ? wd_w : grf_q[ra1];
            if (ra2 != REG_ZERO)
                rd2 = (we_w && (a3 == ra2)) ? wd_w : grf_q[ra2];
        end
    end

    // Register array and retire counter; reset takes priority over a write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                grf_q[i] <= '0;
            cnt_q <= '0;
        end else if (we_w) begin
            grf_q[a3] <= wd_w;
            cnt_q     <= cnt_d;
        end
    end

`ifdef WB_TRACE_EN
    // Simulation trace of each effective write (we_w excludes $0 and reset)
    always_ff @(posedge clk) begin
        if (we_w)
            $display("@%h: $%d <= %h", pc4 - 32'd4, a3, wd_w);
    end
`else
    logic unused_pc4;
    assign unused_pc4 = ^pc4;
`endif

endmodule : wb_stage_grf
`default_nettype wire

// File: tb/tb_wb_stage_grf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage_grf
//  Description : Directed self-checking bench for wb_stage_grf.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_en;
    logic [2:0]  wb_sel;
    logic [2:0]  ld_type;
    logic [4:0]  a3;
    logic [31:0] alu_out, dm_out, imm, hi, lo, pc8, pc4;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2, wd_w, retire_cnt;
    logic        we_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_stage_grf #(.NREG(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_en      (wb_en),
        .wb_sel     (wb_sel),
        .ld_type    (ld_type),
        .a3         (a3),
        .alu_out    (alu_out),
        .dm_out     (dm_out),
        .imm        (imm),
        .hi         (hi),
        .lo         (lo),
        .pc8        (pc8),
        .pc4        (pc4),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .wd_w       (wd_w),
        .we_w       (we_w),
        .retire_cnt (retire_cnt)
    );

    // Advance past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load one register through the ALU path
    task automatic wr_alu(input logic [4:0] idx, input logic [31:0] val);
        wb_en = 1'b1; wb_sel = 3'd0; a3 = idx; alu_out = val;
        tick();
        wb_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wb_en = 1'b0; wb_sel = 3'd0; ld_type = 3'd0; a3 = 5'd0;
        alu_out = 32'h0; dm_out = 32'h0; imm = 32'h0; hi = 32'h0; lo = 32'h0;
        pc8 = 32'h0; pc4 = 32'h0; ra1 = 5'd0; ra2 = 5'd0;
        tick();
        tick();
        reset = 1'b0;

        // 1: everything reads zero after reset
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #1;
            chk($sformatf("rst_rd1[%0d]", i), rd1, 32'h0);
            chk($sformatf("rst_rd2[%0d]", 31 - i), rd2, 32'h0);
        end
        chk("rst_cnt", retire_cnt, 32'h0);
        chk("rst_we", {31'h0, we_w}, 32'h0);

        // 2: ALU write with same-cycle bypass, then from the array
        wb_en = 1'b1; a3 = 5'd5; wb_sel = 3'd0; alu_out = 32'h12345678; ra1 = 5'd5; ra2 = 5'd6;
        #1;
        chk("byp_rd1", rd1, 32'h12345678);
        chk("byp_rd2_other", rd2, 32'h0);
        chk("byp_we", {31'h0, we_w}, 32'h1);
        tick();
        wb_en = 1'b0; alu_out = 32'h0;
        #1;
        chk("arr_rd1", rd1, 32'h12345678);
        chk("cnt_1", retire_cnt, 32'd1);

        // 3: load extension, dm_out = 80F07F01
        wb_sel = 3'd1; dm_out = 32'h80F07F01;
        ld_type = 3'd1; alu_out = 32'd2; #1; chk("lb_off2", wd_w, 32'hFFFFFFF0);
        ld_type = 3'd2; alu_out = 32'd3; #1; chk("lbu_off3", wd_w, 32'h00000080);
        ld_type = 3'd3; alu_out = 32'd2; #1; chk("lh_off2", wd_w, 32'hFFFF80F0);
        ld_type = 3'd4; alu_out = 32'd0; #1; chk("lhu_off0", wd_w, 32'h00007F01);
        ld_type = 3'd3; alu_out = 32'd3; #1; chk("lh_off3", wd_w, 32'hFFFF80F0);
        ld_type = 3'd1; alu_out = 32'd0; #1; chk("lb_off0", wd_w, 32'h00000001);
        ld_type = 3'd2; alu_out = 32'd1; #1; chk("lbu_off1", wd_w, 32'h0000007F);
        ld_type = 3'd3; alu_out = 32'd0; #1; chk("lh_off0", wd_w, 32'h00007F01);
        ld_type = 3'd4; alu_out = 32'd2; #1; chk("lhu_off2", wd_w, 32'h000080F0);
        ld_type = 3'd0; alu_out = 32'd3; #1; chk("lw", wd_w, 32'h80F07F01);
        ld_type = 3'd6; alu_out = 32'd1; #1; chk("ld6_as_lw", wd_w, 32'h80F07F01);
        wb_sel = 3'd0; ld_type = 3'd1; alu_out = 32'h0000ABCE; #1;
        chk("ldtype_ignored_alu", wd_w, 32'h0000ABCE);
        // write a sign-extended byte into $6
        wb_sel = 3'd1; ld_type = 3'd1; alu_out = 32'd3; wb_en = 1'b1; a3 = 5'd6;
        tick();
        wb_en = 1'b0; wb_sel = 3'd0; ld_type = 3'd0; ra2 = 5'd6;
        #1;
        chk("mem_wr_rd2", rd2, 32'hFFFFFF80);
        chk("cnt_2", retire_cnt, 32'd2);

        // 4: write to $0 is discarded and not counted
        wb_en = 1'b1; a3 = 5'd0; wb_sel = 3'd0; alu_out = 32'hDEADBEEF; ra1 = 5'd0;
        #1;
        chk("z_rd1", rd1, 32'h0);
        chk("z_we", {31'h0, we_w}, 32'h0);
        chk("z_wd", wd_w, 32'hDEADBEEF);
        tick();
        wb_en = 1'b0;
        #1;
        chk("z_rd1_after", rd1, 32'h0);
        chk("z_cnt", retire_cnt, 32'd2);

        // 5: other result sources
        pc8 = 32'h00003010; pc4 = 32'h0000300C; hi = 32'h0000000A; lo = 32'h0000000B; imm = 32'h00120000;
        alu_out = 32'h55AA0011;
        wb_en = 1'b1;
        wb_sel = 3'd2; a3 = 5'd7;  #1; chk("pc8_wd", wd_w, 32'h00003010); tick();
        wb_sel = 3'd3; a3 = 5'd8;  #1; chk("hi_wd", wd_w, 32'h0000000A);  tick();
        wb_sel = 3'd4; a3 = 5'd9;  #1; chk("lo_wd", wd_w, 32'h0000000B);  tick();
        wb_sel = 3'd5; a3 = 5'd10; #1; chk("imm_wd", wd_w, 32'h00120000); tick();
        wb_sel = 3'd7; a3 = 5'd11; #1; chk("sel7_wd", wd_w, 32'h55AA0011); tick();
        wb_sel = 3'd6; a3 = 5'd12; #1; chk("sel6_wd", wd_w, 32'h55AA0011); tick();
        wb_en = 1'b0; wb_sel = 3'd0; alu_out = 32'h0;
        ra1 = 5'd7;  ra2 = 5'd8;  #1; chk("rb_r7", rd1, 32'h00003010); chk("rb_r8", rd2, 32'h0000000A);
        ra1 = 5'd9;  ra2 = 5'd10; #1; chk("rb_r9", rd1, 32'h0000000B); chk("rb_r10", rd2, 32'h00120000);
        ra1 = 5'd11; ra2 = 5'd12; #1; chk("rb_r11", rd1, 32'h55AA0011); chk("rb_r12", rd2, 32'h55AA0011);
        ra1 = 5'd5;  ra2 = 5'd6;  #1; chk("rb_r5", rd1, 32'h12345678); chk("rb_r6", rd2, 32'hFFFFFF80);
        chk("cnt_8", retire_cnt, 32'd8);

        // overwrite $5: bypass on port 2 beats the stale array value
        wb_en = 1'b1; a3 = 5'd5; alu_out = 32'hCAFEF00D; ra1 = 5'd6; ra2 = 5'd5;
        #1;
        chk("ovr_byp_rd2", rd2, 32'hCAFEF00D);
        chk("ovr_rd1", rd1, 32'hFFFFFF80);
        tick();
        wb_en = 1'b0;
        #1;
        chk("ovr_arr_rd2", rd2, 32'hCAFEF00D);
        chk("cnt_9", retire_cnt, 32'd9);

        // 6: reset wins over a simultaneous write
        reset = 1'b1; wb_en = 1'b1; a3 = 5'd3; wb_sel = 3'd0; alu_out = 32'h00000033;
        ra1 = 5'd3; ra2 = 5'd5;
        #1;
        chk("rw_rd1", rd1, 32'h0);
        chk("rw_rd2", rd2, 32'h0);
        chk("rw_we", {31'h0, we_w}, 32'h0);
        chk("rw_wd", wd_w, 32'h00000033);
        tick();
        reset = 1'b0; wb_en = 1'b0;
        #1;
        chk("rw_r3", rd1, 32'h0);
        chk("rw_r5", rd2, 32'h0);
        chk("rw_cnt", retire_cnt, 32'h0);

        // a repeated (held) write counts each time
        wr_alu(5'd4, 32'h00000444);
        wb_en = 1'b1; tick(); wb_en = 1'b0;
        ra1 = 5'd4;
        #1;
        chk("rep_r4", rd1, 32'h00000444);
        chk("rep_cnt", retire_cnt, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_wb_stage_grf
`default_nettype wire
